// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct
// values, ALU operation codes and datapath mux select constants.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DCD, S_EXE, S_WB, S_MA, S_MR, S_LWB, S_MW, S_BR, S_JMP
  } state_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                         OP_JAL    = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                         OP_BLEZ   = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08,
                         OP_ADDIU  = 6'h09, OP_SLTI   = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ANDI   = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e,
                         OP_LUI    = 6'h0f, OP_LB     = 6'h20, OP_LH    = 6'h21,
                         OP_LW     = 6'h23, OP_LBU    = 6'h24, OP_LHU   = 6'h25,
                         OP_SB     = 6'h28, OP_SH     = 6'h29, OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                         FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADD  = 6'h20,
                         FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
                         FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND  = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT  = 4'd6, ALU_SLTU = 4'd7,
                         ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;

  localparam logic [1:0] NPC_PC4 = 2'd0, NPC_BR = 2'd1, NPC_JMP = 2'd2, NPC_REG = 2'd3;
  localparam logic [1:0] WA_RT   = 2'd0, WA_RD  = 2'd1, WA_RA   = 2'd2;
  localparam logic [1:0] WD_ALU  = 2'd0, WD_MEM = 2'd1, WD_PC   = 2'd2;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd0, SZ_HALF = 2'd1, SZ_BYTE = 2'd2;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and compare flags in, enables and
// mux selects out. master is the controller side, slave the datapath side.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       eq, ltz, eqz;
  logic       pc_wr;
  logic [1:0] npc_sel;
  logic       ir_wr;
  logic       rf_wr;
  logic [1:0] rf_wa_sel;
  logic [1:0] rf_wd_sel;
  logic       alu_b_sel;
  logic [1:0] ext_op;
  logic [3:0] alu_op;
  logic       dm_wr;
  logic [1:0] dm_size;
  logic       ld_sext;
  logic       done;
  logic       illegal;
  logic [4:0] ra_idx;

  modport master (
    input  op, funct, rt, eq, ltz, eqz,
    output pc_wr, npc_sel, ir_wr, rf_wr, rf_wa_sel, rf_wd_sel, alu_b_sel,
           ext_op, alu_op, dm_wr, dm_size, ld_sext, done, illegal, ra_idx
  );

  modport slave (
    output op, funct, rt, eq, ltz, eqz,
    input  pc_wr, npc_sel, ir_wr, rf_wr, rf_wa_sel, rf_wd_sel, alu_b_sel,
           ext_op, alu_op, dm_wr, dm_size, ld_sext, done, illegal, ra_idx
  );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU decode: maps R-type funct or I-type op to ALU code, B-operand source and
// immediate extension, and flags whether the instruction is a supported ALU op.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       alu_b_sel,
  output logic [1:0] ext_op,
  output logic       r_valid,
  output logic       i_valid
);

  always_comb begin
    alu_op    = ALU_ADD;
    alu_b_sel = 1'b0;
    ext_op    = EXT_SIGN;
    r_valid   = 1'b0;
    i_valid   = 1'b0;
    if (op == OP_RTYPE) begin
      r_valid = 1'b1;
      case (funct)
        FN_ADD, FN_ADDU:   alu_op = ALU_ADD;
        FN_SUB, FN_SUBU:   alu_op = ALU_SUB;
        FN_AND:            alu_op = ALU_AND;
        FN_OR:             alu_op = ALU_OR;
        FN_XOR:            alu_op = ALU_XOR;
        FN_NOR:            alu_op = ALU_NOR;
        FN_SLT:            alu_op = ALU_SLT;
        FN_SLTU:           alu_op = ALU_SLTU;
        FN_SLL, FN_SLLV:   alu_op = ALU_SLL;
        FN_SRL, FN_SRLV:   alu_op = ALU_SRL;
        FN_SRA, FN_SRAV:   alu_op = ALU_SRA;
        default:           r_valid = 1'b0;
      endcase
    end else begin
      alu_b_sel = 1'b1;
      i_valid   = 1'b1;
      case (op)
        OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
        OP_SLTI:           alu_op = ALU_SLT;
        OP_SLTIU:          alu_op = ALU_SLTU;
        OP_ANDI: begin alu_op = ALU_AND; ext_op = EXT_ZERO; end
        OP_ORI:  begin alu_op = ALU_OR;  ext_op = EXT_ZERO; end
        OP_XORI: begin alu_op = ALU_XOR; ext_op = EXT_ZERO; end
        OP_LUI:  begin alu_op = ALU_LUI; ext_op = EXT_LUI;  end
        default:           i_valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: fetch, decode, execute/memory/branch/jump and
// writeback, driving every datapath enable and mux select.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned RA_REG = 31
) (
  input  logic         clk,
  input  logic         rst,
  mc_ctrl_if.master    bus
);

  state_e     state_q, state_d;
  logic [3:0] dec_alu_op;
  logic       dec_b_sel, dec_r_valid, dec_i_valid;
  logic [1:0] dec_ext_op;
  logic       is_load, is_store, is_branch, is_jump, is_rjump, br_taken;
  logic [1:0] mem_size;

  mc_alu_dec u_alu_dec (
    .op        (bus.op),
    .funct     (bus.funct),
    .alu_op    (dec_alu_op),
    .alu_b_sel (dec_b_sel),
    .ext_op    (dec_ext_op),
    .r_valid   (dec_r_valid),
    .i_valid   (dec_i_valid)
  );

  assign is_load   = (bus.op == OP_LW) || (bus.op == OP_LH) || (bus.op == OP_LHU) ||
                     (bus.op == OP_LB) || (bus.op == OP_LBU);
  assign is_store  = (bus.op == OP_SW) || (bus.op == OP_SH) || (bus.op == OP_SB);
  assign is_rjump  = (bus.op == OP_RTYPE) && ((bus.funct == FN_JR) || (bus.funct == FN_JALR));
  assign is_jump   = (bus.op == OP_J) || (bus.op == OP_JAL) || is_rjump;
  // REGIMM only supports bltz (rt=0) and bgez (rt=1)
  assign is_branch = (bus.op == OP_BEQ) || (bus.op == OP_BNE) || (bus.op == OP_BLEZ) ||
                     (bus.op == OP_BGTZ) || ((bus.op == OP_REGIMM) && (bus.rt[4:1] == 4'd0));
  assign mem_size  = ((bus.op == OP_LH) || (bus.op == OP_LHU) || (bus.op == OP_SH)) ? SZ_HALF :
                     ((bus.op == OP_LB) || (bus.op == OP_LBU) || (bus.op == OP_SB)) ? SZ_BYTE :
                     SZ_WORD;
  assign bus.ra_idx = 5'(RA_REG);

  always_comb begin
    case (bus.op)
      OP_BEQ:    br_taken = bus.eq;
      OP_BNE:    br_taken = !bus.eq;
      OP_BLEZ:   br_taken = bus.ltz || bus.eqz;
      OP_BGTZ:   br_taken = !bus.ltz && !bus.eqz;
      OP_REGIMM: br_taken = bus.rt[0] ? !bus.ltz : bus.ltz;
      default:   br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.pc_wr     = 1'b0;
    bus.npc_sel   = NPC_PC4;
    bus.ir_wr     = 1'b0;
    bus.rf_wr     = 1'b0;
    bus.rf_wa_sel = WA_RT;
    bus.rf_wd_sel = WD_ALU;
    bus.alu_b_sel = 1'b0;
    bus.ext_op    = EXT_ZERO;
    bus.alu_op    = ALU_ADD;
    bus.dm_wr     = 1'b0;
    bus.dm_size   = SZ_WORD;
    bus.ld_sext   = 1'b0;
    bus.done      = 1'b0;
    bus.illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.pc_wr = 1'b1;
        bus.ir_wr = 1'b1;
        state_d   = S_DCD;
      end
      S_DCD: begin
        if (dec_r_valid || dec_i_valid) state_d = S_EXE;
        else if (is_load || is_store)   state_d = S_MA;
        else if (is_branch)             state_d = S_BR;
        else if (is_jump)               state_d = S_JMP;
        else begin
          bus.illegal = 1'b1;
          bus.done    = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_EXE: begin
        bus.alu_op    = dec_alu_op;
        bus.alu_b_sel = dec_b_sel;
        bus.ext_op    = dec_ext_op;
        state_d       = S_WB;
      end
      S_WB: begin
        bus.rf_wr     = 1'b1;
        bus.rf_wa_sel = (bus.op == OP_RTYPE) ? WA_RD : WA_RT;
        bus.done      = 1'b1;
        state_d       = S_FETCH;
      end
      S_MA: begin
        bus.alu_b_sel = 1'b1;
        bus.ext_op    = EXT_SIGN;
        state_d       = is_load ? S_MR : S_MW;
      end
      S_MR: begin
        bus.dm_size = mem_size;
        bus.ld_sext = (bus.op == OP_LH) || (bus.op == OP_LB);
        state_d     = S_LWB;
      end
      S_LWB: begin
        bus.rf_wr     = 1'b1;
        bus.rf_wd_sel = WD_MEM;
        bus.dm_size   = mem_size;
        bus.ld_sext   = (bus.op == OP_LH) || (bus.op == OP_LB);
        bus.done      = 1'b1;
        state_d       = S_FETCH;
      end
      S_MW: begin
        bus.dm_wr   = 1'b1;
        bus.dm_size = mem_size;
        bus.done    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BR: begin
        bus.pc_wr   = br_taken;
        bus.npc_sel = NPC_BR;
        bus.done    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JMP: begin
        bus.pc_wr = 1'b1;
        bus.done  = 1'b1;
        state_d   = S_FETCH;
        if (bus.op == OP_RTYPE) begin
          bus.npc_sel = NPC_REG;
          if (bus.funct == FN_JALR) begin
            bus.rf_wr     = 1'b1;
            bus.rf_wa_sel = WA_RD;
            bus.rf_wd_sel = WD_PC;
          end
        end else begin
          bus.npc_sel = NPC_JMP;
          if (bus.op == OP_JAL) begin
            bus.rf_wr     = 1'b1;
            bus.rf_wa_sel = WA_RA;
            bus.rf_wd_sel = WD_PC;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
    // reset masks every enable and select, so an aborted instruction writes nothing
    if (rst) begin
      bus.pc_wr     = 1'b0;
      bus.npc_sel   = '0;
      bus.ir_wr     = 1'b0;
      bus.rf_wr     = 1'b0;
      bus.rf_wa_sel = '0;
      bus.rf_wd_sel = '0;
      bus.alu_b_sel = 1'b0;
      bus.ext_op    = '0;
      bus.alu_op    = '0;
      bus.dm_wr     = 1'b0;
      bus.dm_size   = '0;
      bus.ld_sext   = 1'b0;
      bus.done      = 1'b0;
      bus.illegal   = 1'b0;
    end
  end

endmodule
